// File: rtl/cpu65xx_pkg.sv
// Shared definitions for the 65xx interrupt/reset sequencer: sequence state
// encoding, interrupt source codes, push-source selects and vector addresses.
package cpu65xx_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ADDR_W  = 16;

  // Sequence states, in execution order.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_DUM1     = 3'd1,
    ST_DUM2     = 3'd2,
    ST_PUSH_PCH = 3'd3,
    ST_PUSH_PCL = 3'd4,
    ST_PUSH_P   = 3'd5,
    ST_VEC_LO   = 3'd6,
    ST_VEC_HI   = 3'd7
  } seq_state_e;

  // Latched interrupt source for the running sequence.
  typedef enum logic [SRC_W-1:0] {
    SRC_RESET = 2'd0,
    SRC_NMI   = 2'd1,
    SRC_IRQ   = 2'd2,
    SRC_BRK   = 2'd3
  } int_src_e;

  localparam logic [SEL_W-1:0] PUSH_SEL_PCH = 2'd0;
  localparam logic [SEL_W-1:0] PUSH_SEL_PCL = 2'd1;
  localparam logic [SEL_W-1:0] PUSH_SEL_P   = 2'd2;

  localparam logic [ADDR_W-1:0] VEC_NMI   = 16'hFFFA;
  localparam logic [ADDR_W-1:0] VEC_RESET = 16'hFFFC;
  localparam logic [ADDR_W-1:0] VEC_IRQ   = 16'hFFFE;

  // Low byte address of the vector belonging to a source.
  function automatic logic [ADDR_W-1:0] vec_base(input int_src_e src);
    case (src)
      SRC_RESET: vec_base = VEC_RESET;
      SRC_NMI:   vec_base = VEC_NMI;
      default:   vec_base = VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/cpu65xx_nmi_edge.sv
// NMI falling-edge detector and pending latch.
// Ports: clk, rst (async, active-high), nmi_n (pin), pend_clr (clear request
// from the sequencer), pend (registered NMI-pending flag).
module cpu65xx_nmi_edge (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic pend_clr,
  output logic pend
);

  logic nmi_prev;
  logic nmi_fall;

  // History resets high so a pin already low at release is not an edge.
  assign nmi_fall = nmi_prev & ~nmi_n;

  // A new edge in the clear cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_prev <= 1'b1;
      pend     <= 1'b0;
    end else begin
      nmi_prev <= nmi_n;
      pend     <= nmi_fall | (pend & ~pend_clr);
    end
  end

endmodule

// File: rtl/cpu65xx_int_ctrl.sv
// 65xx interrupt/reset sequence controller. Accepts reset, NMI, IRQ and BRK
// requests, then steps through two dummy reads, three stack pushes and a
// two-byte vector fetch.
// Inputs : Clk, Rst (async high), Rdy, Sync, ResReq, Nmi_n, Irq_n, IFlag, BrkReq
// Outputs: SeqActive, SeqState, PushW, PushSel, VecPull, VectorAddr, BFlag,
//          SetI, ClrD, SeqDone
module cpu65xx_int_ctrl
  import cpu65xx_pkg::*;
#(
  parameter bit pIsCmosEn = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rdy,
  input  logic              Sync,
  input  logic              ResReq,
  input  logic              Nmi_n,
  input  logic              Irq_n,
  input  logic              IFlag,
  input  logic              BrkReq,
  output logic              SeqActive,
  output logic [STATE_W-1:0] SeqState,
  output logic              PushW,
  output logic [SEL_W-1:0]  PushSel,
  output logic              VecPull,
  output logic [ADDR_W-1:0] VectorAddr,
  output logic              BFlag,
  output logic              SetI,
  output logic              ClrD,
  output logic              SeqDone
);

  seq_state_e state, state_d;
  int_src_e   src, src_d;
  logic       res_pend, res_pend_d;
  logic       nmi_pend;
  logic       nmi_clr;
  logic       vlo_entry;

  logic              seq_active_d;
  logic              push_w_d;
  logic [SEL_W-1:0]  push_sel_d;
  logic              vec_pull_d;
  logic [ADDR_W-1:0] vector_addr_d;
  logic              bflag_d;
  logic              set_i_d;
  logic              clr_d_d;

  cpu65xx_nmi_edge u_nmi_edge (
    .clk      (Clk),
    .rst      (Rst),
    .nmi_n    (Nmi_n),
    .pend_clr (nmi_clr),
    .pend     (nmi_pend)
  );

  // State, source and reset-pending registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      src      <= SRC_RESET;
      res_pend <= 1'b1;
    end else begin
      state    <= state_d;
      src      <= src_d;
      res_pend <= res_pend_d;
    end
  end

  // Next state, source latch and NMI hijack.
  always_comb begin
    state_d    = state;
    src_d      = src;
    res_pend_d = res_pend;
    if (ResReq) begin
      state_d    = ST_IDLE;
      res_pend_d = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (res_pend) begin
            state_d    = ST_DUM1;
            src_d      = SRC_RESET;
            res_pend_d = 1'b0;
          end else if (Sync && Rdy) begin
            if (nmi_pend) begin
              state_d = ST_DUM1;
              src_d   = SRC_NMI;
            end else if (!Irq_n && !IFlag) begin
              state_d = ST_DUM1;
              src_d   = SRC_IRQ;
            end else if (BrkReq) begin
              state_d = ST_DUM1;
              src_d   = SRC_BRK;
            end
          end
        end
        ST_DUM1:     if (Rdy) state_d = ST_DUM2;
        ST_DUM2:     if (Rdy) state_d = ST_PUSH_PCH;
        ST_PUSH_PCH: state_d = ST_PUSH_PCL;
        ST_PUSH_PCL: state_d = ST_PUSH_P;
        ST_PUSH_P: begin
          state_d = ST_VEC_LO;
          // NMOS parts let a pending NMI steal the IRQ/BRK vector fetch.
          if (!pIsCmosEn && nmi_pend && (src == SRC_IRQ || src == SRC_BRK))
            src_d = SRC_NMI;
        end
        ST_VEC_LO:   if (Rdy) state_d = ST_VEC_HI;
        ST_VEC_HI:   if (Rdy) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  assign vlo_entry = (state == ST_PUSH_P) && (state_d == ST_VEC_LO);
  assign nmi_clr   = vlo_entry && (src_d == SRC_NMI);

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    seq_active_d  = (state_d != ST_IDLE);
    push_w_d      = 1'b0;
    push_sel_d    = PUSH_SEL_PCH;
    vec_pull_d    = 1'b0;
    vector_addr_d = '0;
    bflag_d       = 1'b0;
    set_i_d       = vlo_entry;
    clr_d_d       = vlo_entry && pIsCmosEn;
    case (state_d)
      ST_PUSH_PCH: begin
        push_w_d   = (src_d != SRC_RESET);
        push_sel_d = PUSH_SEL_PCH;
      end
      ST_PUSH_PCL: begin
        push_w_d   = (src_d != SRC_RESET);
        push_sel_d = PUSH_SEL_PCL;
      end
      ST_PUSH_P: begin
        push_w_d   = (src_d != SRC_RESET);
        push_sel_d = PUSH_SEL_P;
        bflag_d    = (src_d == SRC_BRK);
      end
      ST_VEC_LO: begin
        vec_pull_d    = 1'b1;
        vector_addr_d = vec_base(src_d);
      end
      ST_VEC_HI: begin
        vec_pull_d    = 1'b1;
        vector_addr_d = vec_base(src_d) + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      SeqActive  <= 1'b0;
      PushW      <= 1'b0;
      PushSel    <= PUSH_SEL_PCH;
      VecPull    <= 1'b0;
      VectorAddr <= '0;
      BFlag      <= 1'b0;
      SetI       <= 1'b0;
      ClrD       <= 1'b0;
    end else begin
      SeqActive  <= seq_active_d;
      PushW      <= push_w_d;
      PushSel    <= push_sel_d;
      VecPull    <= vec_pull_d;
      VectorAddr <= vector_addr_d;
      BFlag      <= bflag_d;
      SetI       <= set_i_d;
      ClrD       <= clr_d_d;
    end
  end

  assign SeqState = STATE_W'(state);

  // Completion depends on this cycle's Rdy, so it cannot be registered ahead.
  assign SeqDone = (state == ST_VEC_HI) && Rdy;

endmodule

// File: doc/cpu65xx_int_ctrl.md
CPU65XX_INT_CTRL -- requirements
Module: cpu65xx_int_ctrl

Interface
REQ-001 Parameter pIsCmosEn, default 0, meaning CMOS interrupt behaviour (D cleared, no NMI hijack).
REQ-002 Clk  input  1  single clock; all state on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 Rdy  input  1  core ready; 0 stalls read-type sequence cycles.
REQ-005 Sync  input  1  instruction-boundary strobe from core.
REQ-006 ResReq  input  1  CPU reset request (level, high = held in reset).
REQ-007 Nmi_n  input  1  NMI pin, falling-edge sensitive.
REQ-008 Irq_n  input  1  IRQ pin, level, active-low.
REQ-009 IFlag  input  1  current P.I interrupt-disable flag.
REQ-010 BrkReq  input  1  BRK opcode decoded, valid with Sync.
REQ-011 SeqActive  output  1  interrupt/reset sequence in progress.
REQ-012 SeqState  output  3  current sequence state encoding.
REQ-013 PushW  output  1  write strobe for stack-push cycles.
REQ-014 PushSel  output  2  push source: 0 PCH, 1 PCL, 2 P.
REQ-015 VecPull  output  1  vector fetch cycle (drives VPB).
REQ-016 VectorAddr  output  16  vector fetch address.
REQ-017 BFlag  output  1  B bit value for pushed P.
REQ-018 SetI  output  1  one-cycle pulse: set P.I.
REQ-019 ClrD  output  1  one-cycle pulse: clear P.D (pIsCmosEn=1 only, else 0).
REQ-020 SeqDone  output  1  one-cycle pulse at sequence completion.

Function
REQ-021 States SHALL be IDLE, DUM1, DUM2, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, in that order; IDLE->DUM1 on acceptance, else linear, VEC_HI->IDLE.
REQ-022 Source priority SHALL be reset > NMI > IRQ > BRK; latched source held for whole sequence except REQ-029.
REQ-023 ResReq=1 SHALL force IDLE, set reset-pending, deassert all outputs; on ResReq 1->0 sequence starts next cycle without Sync.
REQ-024 NMI/IRQ/BRK SHALL be accepted only in IDLE when Sync=1 and Rdy=1; IRQ only if Irq_n=0 and IFlag=0.
REQ-025 Falling edge of Nmi_n SHALL set NmiPend; NmiPend cleared on entry to VEC_LO of an NMI vector; edge during clear cycle re-sets it (set wins).
REQ-026 Read cycles (DUM1, DUM2, VEC_LO, VEC_HI) SHALL hold while Rdy=0; push cycles SHALL advance regardless of Rdy.
REQ-027 PushW=1 in PUSH_* states, except reset sequence where PushW=0 (dummy reads); PushSel per REQ-014.
REQ-028 VectorAddr: NMI FFFA, reset FFFC, IRQ/BRK FFFE in VEC_LO; +1 in VEC_HI; VecPull=1 in both; 0000 otherwise.
REQ-029 pIsCmosEn=0: NmiPend set before VEC_LO during IRQ/BRK sequence SHALL redirect vector to FFFA (hijack), BFlag unchanged; pIsCmosEn=1: no redirect, NMI taken at next boundary.
REQ-030 BFlag=1 for BRK, 0 for IRQ/NMI/reset, valid in PUSH_P.
REQ-031 SetI (and ClrD if pIsCmosEn=1) SHALL pulse on VEC_LO entry cycle; SeqDone pulses in last VEC_HI cycle with Rdy=1.
REQ-032 Latency: acceptance to VEC_HI completion SHALL be exactly 7 cycles with Rdy=1 throughout.
REQ-033 SeqActive=1 in all non-IDLE states; new requests ignored while active (NMI still latched).

Reset
REQ-034 Rst=1 SHALL asynchronously force IDLE, NmiPend=0, reset-pending=1, all outputs 0; after release reset sequence runs once ResReq=0.
REQ-035 Nmi_n edge history SHALL reset to 1 (no spurious edge if Nmi_n low at release).

Structure
REQ-036 State encodings, PushSel codes and vector constants SHALL live in shared package cpu65xx_pkg.
REQ-037 NMI edge detect/pending latch SHALL be sub-module cpu65xx_nmi_edge.

Verification
REQ-038 Rst release, ResReq=0: 7 cycles, PushW=0 throughout, VectorAddr FFFC then FFFD, SetI one pulse.
REQ-039 Irq_n=0, IFlag=0, Sync=1: pushes PCH/PCL/P with BFlag=0, VectorAddr FFFE/FFFF; IFlag=1 -> no sequence.
REQ-040 Nmi_n falls during PUSH_PCL of BRK, pIsCmosEn=0: VectorAddr FFFA/FFFB, BFlag=1, NmiPend cleared; pIsCmosEn=1: FFFE, NMI sequence follows at next Sync.
REQ-041 Rdy=0 for 3 cycles in DUM2 and in PUSH_PCH: DUM2 holds 3 cycles, PUSH_PCH advances; total 10 cycles.
REQ-042 ResReq asserted mid-IRQ sequence in PUSH_P: next cycle IDLE, outputs 0; ResReq release -> reset sequence, FFFC.
